// File: rtl/alexcpt_wr_sched.sv
// alexcpt_wr_sched: write-side controller for the active-list exception RAM.
// Clears the RAM after reset/flush, then merges reporters onto two write ports with in-order overflow buffering.
module alexcpt_wr_sched #(
    parameter int DEPTH     = 16,
    parameter int INDEX     = 4,
    parameter int WIDTH     = 8,
    parameter int NUM_SRC   = 3,
    parameter int BUF_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic [NUM_SRC-1:0]             srcValid_i,
    input  logic [NUM_SRC*INDEX-1:0]       srcAddr_i,
    input  logic [NUM_SRC*WIDTH-1:0]       srcData_i,
    output logic                           stall_o,
    output logic [INDEX-1:0]               addr0wr_o,
    output logic [WIDTH-1:0]               data0wr_o,
    output logic                           we0_o,
    output logic [INDEX-1:0]               addr1wr_o,
    output logic [WIDTH-1:0]               data1wr_o,
    output logic                           we1_o,
    output logic                           ready_o,
    output logic [$clog2(BUF_DEPTH):0]     bufCount_o
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [INDEX:0]    cnt_q, cnt_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [INDEX-1:0]  buf_addr_q [BUF_DEPTH];
    logic [WIDTH-1:0]  buf_data_q [BUF_DEPTH];
    logic [INDEX-1:0]  addr0_d, addr1_d;
    logic [WIDTH-1:0]  data0_d, data1_d;
    logic              we0_d, we1_d, ready_d, ovf;
    logic              c0_v, c1_v;
    logic [INDEX-1:0]  c0_a, c1_a;
    logic [WIDTH-1:0]  c0_d, c1_d;
    logic [NUM_SRC-1:0] push_en;
    logic [PW-1:0]     push_idx [NUM_SRC];
    int                n_buf, rank, issue, pop, base, free, slot, pushed;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int n);
        return PW'((int'(p) + n) % BUF_DEPTH);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we0_d   = 1'b0;
        we1_d   = 1'b0;
        addr0_d = '0;
        addr1_d = '0;
        data0_d = '0;
        data1_d = '0;
        ready_d = 1'b0;
        ovf     = 1'b0;
        push_en = '0;
        for (int j = 0; j < NUM_SRC; j++) push_idx[j] = '0;
        c0_v = 1'b0;
        c1_v = 1'b0;
        c0_a = '0;
        c1_a = '0;
        c0_d = '0;
        c1_d = '0;
        slot = 0;
        n_buf = int'(count_q);
        if (n_buf >= 1) begin
            c0_v = 1'b1;
            c0_a = buf_addr_q[head_q];
            c0_d = buf_data_q[head_q];
        end
        if (n_buf >= 2) begin
            c1_v = 1'b1;
            c1_a = buf_addr_q[wrap(head_q, 1)];
            c1_d = buf_data_q[wrap(head_q, 1)];
        end
        // New sources rank behind everything already buffered.
        rank = n_buf;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (srcValid_i[j]) begin
                if (rank == 0) begin
                    c0_v = 1'b1;
                    c0_a = srcAddr_i[j*INDEX +: INDEX];
                    c0_d = srcData_i[j*WIDTH +: WIDTH];
                end else if (rank == 1) begin
                    c1_v = 1'b1;
                    c1_a = srcAddr_i[j*INDEX +: INDEX];
                    c1_d = srcData_i[j*WIDTH +: WIDTH];
                end
                rank++;
            end
        end
        issue  = c0_v ? ((c1_v && c1_a != c0_a) ? 2 : 1) : 0;
        pop    = (issue < n_buf) ? issue : n_buf;
        base   = (issue > n_buf) ? issue : n_buf;
        free   = BUF_DEPTH - (n_buf - pop);
        pushed = 0;
        if (flush_i) begin
            state_d = CLEAR;
            cnt_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (state_q == CLEAR) begin
            we0_d   = 1'b1;
            we1_d   = 1'b1;
            addr0_d = cnt_q[INDEX-1:0];
            addr1_d = INDEX'(cnt_q + 1'b1);
            cnt_d   = cnt_q + (INDEX+1)'(2);
            state_d = (cnt_q == (INDEX+1)'(DEPTH-2)) ? RUN : CLEAR;
        end else begin
            ready_d = 1'b1;
            we0_d   = c0_v;
            addr0_d = c0_a;
            data0_d = c0_d;
            we1_d   = (issue == 2);
            addr1_d = (issue == 2) ? c1_a : '0;
            data1_d = (issue == 2) ? c1_d : '0;
            rank = n_buf;
            for (int j = 0; j < NUM_SRC; j++) begin
                if (srcValid_i[j]) begin
                    if (rank >= issue) begin
                        slot = rank - base;
                        if (slot < free) begin
                            push_en[j]  = 1'b1;
                            push_idx[j] = wrap(tail_q, slot);
                            pushed++;
                        end else begin
                            ovf = 1'b1;
                        end
                    end
                    rank++;
                end
            end
            head_d  = wrap(head_q, pop);
            tail_d  = wrap(tail_q, pushed);
            count_d = CW'(n_buf - pop + pushed);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            we0_o     <= 1'b0;
            we1_o     <= 1'b0;
            addr0wr_o <= '0;
            addr1wr_o <= '0;
            data0wr_o <= '0;
            data1wr_o <= '0;
            ready_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            we0_o     <= we0_d;
            we1_o     <= we1_d;
            addr0wr_o <= addr0_d;
            addr1wr_o <= addr1_d;
            data0wr_o <= data0_d;
            data1wr_o <= data1_d;
            ready_o   <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!ovf);
        for (int j = 0; j < NUM_SRC; j++) begin
            if (!reset && push_en[j]) begin
                buf_addr_q[push_idx[j]] <= srcAddr_i[j*INDEX +: INDEX];
                buf_data_q[push_idx[j]] <= srcData_i[j*WIDTH +: WIDTH];
            end
        end
    end

    assign stall_o    = !ready_o || (count_q > CW'(BUF_DEPTH - NUM_SRC));
    assign bufCount_o = count_q;
endmodule

// File: tb/tb_alexcpt_wr_sched.sv
// tb_alexcpt_wr_sched: randomized and directed checks of the exception-RAM write scheduler
// against a queue-based reference model.
module tb_alexcpt_wr_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic [2:0]  src_v = '0;
    logic [11:0] src_a = '0;
    logic [23:0] src_d = '0;
    logic        stall_o, we0_o, we1_o, ready_o;
    logic [3:0]  addr0wr_o, addr1wr_o;
    logic [7:0]  data0wr_o, data1wr_o;
    logic [2:0]  bufCount_o;
    logic [30:0] obs, exp_v;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } rec_t;

    rec_t       q[$];
    logic       mclr = 1'b1;
    int         mcnt = 0;
    logic       erdy = 1'b0;
    logic       estall = 1'b1;
    logic [7:0] ram_dut [16];
    logic [7:0] ram_ref [16];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alexcpt_wr_sched dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .srcValid_i(src_v), .srcAddr_i(src_a), .srcData_i(src_d),
        .stall_o(stall_o),
        .addr0wr_o(addr0wr_o), .data0wr_o(data0wr_o), .we0_o(we0_o),
        .addr1wr_o(addr1wr_o), .data1wr_o(data1wr_o), .we1_o(we1_o),
        .ready_o(ready_o), .bufCount_o(bufCount_o)
    );

    assign obs = {we0_o, addr0wr_o, data0wr_o, we1_o, addr1wr_o, data1wr_o, ready_o, stall_o, bufCount_o};

    // One clock edge: apply inputs, advance the reference model, and mirror DUT writes into a RAM image.
    task automatic tick(input logic r, input logic f, input logic [2:0] v,
                        input logic [11:0] a, input logic [23:0] d);
        rec_t l[$];
        rec_t t;
        logic       w0, w1;
        logic [3:0] a0, a1;
        logic [7:0] d0, d1;
        reset = r; flush_i = f; src_v = v; src_a = a; src_d = d;
        @(posedge clk);
        w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        if (r || f) begin
            mclr = 1; mcnt = 0; q.delete(); erdy = 0;
        end else if (mclr) begin
            w0 = 1; a0 = 4'(mcnt); w1 = 1; a1 = 4'(mcnt + 1);
            ram_ref[a0] = 0; ram_ref[a1] = 0;
            mcnt += 2;
            if (mcnt == 16) mclr = 0;
            erdy = 0;
        end else begin
            erdy = 1;
            l = q;
            for (int j = 0; j < 3; j++) if (v[j]) l.push_back({a[j*4 +: 4], d[j*8 +: 8]});
            if (l.size() > 0) begin
                t = l.pop_front();
                w0 = 1; a0 = t.a; d0 = t.d; ram_ref[t.a] = t.d;
                if (l.size() > 0 && l[0].a != t.a) begin
                    t = l.pop_front();
                    w1 = 1; a1 = t.a; d1 = t.d; ram_ref[t.a] = t.d;
                end
            end
            q = l;
        end
        estall = !erdy || q.size() > 1;
        exp_v = {w0, a0, d0, w1, a1, d1, erdy, estall, 3'(q.size())};
        #1;
        if (we0_o) ram_dut[addr0wr_o] = data0wr_o;
        if (we1_o) ram_dut[addr1wr_o] = data1wr_o;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 3'($urandom), 12'($urandom), 24'($urandom));
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_model: got %h want %h", obs, exp_v);
            end
            checks++;
            if ({ready_o, stall_o, bufCount_o, we0_o, we1_o} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_values: rdy=%b stall=%b cnt=%0d we=%b%b", ready_o, stall_o, bufCount_o, we0_o, we1_o);
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 9; i++) begin
            if (i < 5) tick(0, 0, 3'($urandom), 12'($urandom), 24'($urandom));
            else idle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clear_model[%0d]: got %h want %h", i, obs, exp_v);
            end
            checks++;
            if (i < 8 && {we0_o, addr0wr_o, data0wr_o, we1_o, addr1wr_o, data1wr_o, ready_o}
                        !== {1'b1, 4'(2*i), 8'h00, 1'b1, 4'(2*i+1), 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL clear_pair[%0d]: got %h/%h want %0d/%0d", i, addr0wr_o, addr1wr_o, 2*i, 2*i+1);
            end else if (i == 8 && {ready_o, stall_o, we0_o, we1_o} !== 4'b1000) begin
                errors++;
                $display("FAIL clear_done: rdy=%b stall=%b we=%b%b want 1 0 00", ready_o, stall_o, we0_o, we1_o);
            end
        end
    endtask

    task automatic test_two_src();
        tick(0, 0, 3'b101, {4'd5, 4'd0, 4'd3}, {8'h22, 8'h00, 8'h11});
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL two_src_model: got %h want %h", obs, exp_v);
        end
        checks++;
        if ({we0_o, addr0wr_o, data0wr_o, we1_o, addr1wr_o, data1wr_o, bufCount_o}
            !== {1'b1, 4'd3, 8'h11, 1'b1, 4'd5, 8'h22, 3'd0}) begin
            errors++;
            $display("FAIL two_src: got %h want port0 3/11 port1 5/22 cnt 0", obs);
        end
    endtask

    task automatic test_three_src();
        tick(0, 0, 3'b111, {4'd4, 4'd2, 4'd1}, {8'h44, 8'h33, 8'h31});
        checks++;
        if (obs !== exp_v || {we0_o, addr0wr_o, we1_o, addr1wr_o, bufCount_o} !== {1'b1, 4'd1, 1'b1, 4'd2, 3'd1}) begin
            errors++;
            $display("FAIL three_src_n1: got %h want %h", obs, exp_v);
        end
        tick(0, 0, 3'b001, {4'd0, 4'd0, 4'd7}, {8'h00, 8'h00, 8'h77});
        checks++;
        if (obs !== exp_v || {addr0wr_o, data0wr_o, addr1wr_o, data1wr_o, bufCount_o} !== {4'd4, 8'h44, 4'd7, 8'h77, 3'd0}) begin
            errors++;
            $display("FAIL three_src_n2: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_same_addr();
        tick(0, 0, 3'b011, {4'd0, 4'd6, 4'd6}, {8'h00, 8'h0B, 8'h0A});
        checks++;
        if (obs !== exp_v || {we0_o, addr0wr_o, data0wr_o, we1_o, bufCount_o} !== {1'b1, 4'd6, 8'h0A, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL same_addr_n1: got %h want %h", obs, exp_v);
        end
        idle();
        checks++;
        if (obs !== exp_v || {we0_o, addr0wr_o, data0wr_o, we1_o} !== {1'b1, 4'd6, 8'h0B, 1'b0}) begin
            errors++;
            $display("FAIL same_addr_n2: got %h want %h", obs, exp_v);
        end
        checks++;
        if (ram_dut[6] !== 8'h0B) begin
            errors++;
            $display("FAIL same_addr_ram: got %h want 0b", ram_dut[6]);
        end
    endtask

    task automatic test_stall();
        logic [2:0] want_cnt [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        logic       want_stl [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) tick(0, 0, 3'b011, {4'd0, 4'd9, 4'd9}, {8'h00, 8'(8'hB0 + i), 8'(8'hA0 + i)});
            else idle();
            checks++;
            if (obs !== exp_v || {bufCount_o, stall_o} !== {want_cnt[i], want_stl[i]}) begin
                errors++;
                $display("FAIL stall[%0d]: got %h want %h cnt=%0d stall=%b", i, obs, exp_v, want_cnt[i], want_stl[i]);
            end
        end
    endtask

    task automatic test_flush();
        tick(0, 0, 3'b011, {4'd0, 4'd8, 4'd8}, 24'h00_C1_C0);
        tick(0, 0, 3'b011, {4'd0, 4'd8, 4'd8}, 24'h00_C3_C2);
        checks++;
        if (bufCount_o !== 3'd2) begin
            errors++;
            $display("FAIL flush_setup: got cnt %0d want 2", bufCount_o);
        end
        tick(0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_v || {ready_o, stall_o, bufCount_o, we0_o, we1_o} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_run: got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) idle();
        tick(0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_v || {we0_o, we1_o, ready_o} !== 3'b000) begin
            errors++;
            $display("FAIL flush_clear: got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 9; i++) begin
            idle();
            checks++;
            if (obs !== exp_v || ready_o !== (i == 8) || (i == 0 && {addr0wr_o, addr1wr_o, we0_o} !== {4'd0, 4'd1, 1'b1})) begin
                errors++;
                $display("FAIL flush_walk[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] v;
        logic       f;
        for (int i = 0; i < 400; i++) begin
            v = estall ? 3'b000 : 3'($urandom);
            f = ($urandom_range(0, 59) == 0);
            tick(0, f, v, {1'b0, 3'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom)}, 24'($urandom));
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ram_dut[i] !== ram_ref[i]) begin
                errors++;
                $display("FAIL ram[%0d]: got %h want %h", i, ram_dut[i], ram_ref[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_dut[i] = 8'hFF;
            ram_ref[i] = 8'hFF;
        end
        test_reset();
        test_clear();
        test_two_src();
        test_three_src();
        test_same_addr();
        test_stall();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
